// File: rtl/ccff_loader_if.sv
// Word-stream handshake between the bitstream source and the ccff loader.
interface ccff_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_loader.sv
// Serializes a word stream into the fabric configuration chain and measures
// chain length with a single-pulse integrity check.
module ccff_loader #(
  parameter int CHAIN_LEN    = 29647,
  parameter int WORD_W       = 32,
  parameter int CNT_W        = 16,
  parameter int CHECK_MARGIN = 8
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             start_load,
  input  logic             start_check,
  ccff_loader_if.slave     s_if,
  output logic             ccff_head,
  output logic             ccff_clk_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             config_done,
  output logic             check_pass,
  output logic             check_fail,
  output logic [CNT_W-1:0] bit_count
);

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(CHAIN_LEN + CHECK_MARGIN);
  localparam logic [WB_W-1:0]  WORD_LAST = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_SHIFT, CHK, DONE} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [WB_W-1:0]     wbit_q;
  logic [CNT_W-1:0]    bit_count_q;
  logic [CNT_W-1:0]    cnt_inc_d;
  logic                s_ready_q;
  logic                head_q;
  logic                clk_en_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                fail_q;

  assign cnt_inc_d = bit_count_q + CNT_W'(1);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      wbit_q      <= '0;
      bit_count_q <= '0;
      s_ready_q   <= 1'b0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_load || start_check) begin
            bit_count_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b1;
            if (start_load) begin
              state_q   <= LD_WAIT;
              s_ready_q <= 1'b1;
            end else begin
              // The check pulse goes out on the very first enabled cycle.
              state_q  <= CHK;
              clk_en_q <= 1'b1;
              head_q   <= 1'b1;
            end
          end
        end

        LD_WAIT: begin
          if (s_if.s_valid) begin
            word_q    <= s_if.s_data >> 1;
            head_q    <= s_if.s_data[0];
            wbit_q    <= '0;
            clk_en_q  <= 1'b1;
            s_ready_q <= 1'b0;
            state_q   <= LD_SHIFT;
          end
        end

        LD_SHIFT: begin
          bit_count_q <= cnt_inc_d;
          if (cnt_inc_d == LEN_C) begin
            // Remaining MSBs of the final word are dropped here.
            state_q  <= DONE;
            clk_en_q <= 1'b0;
            head_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (wbit_q == WORD_LAST) begin
            state_q   <= LD_WAIT;
            clk_en_q  <= 1'b0;
            head_q    <= 1'b0;
            s_ready_q <= 1'b1;
          end else begin
            head_q <= word_q[0];
            word_q <= word_q >> 1;
            wbit_q <= wbit_q + WB_W'(1);
          end
        end

        CHK: begin
          if (ccff_tail) begin
            // Arrival count is the number of shifts already completed.
            pass_q   <= (bit_count_q == LEN_C);
            fail_q   <= (bit_count_q != LEN_C);
            state_q  <= DONE;
            clk_en_q <= 1'b0;
            head_q   <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            bit_count_q <= cnt_inc_d;
            head_q      <= 1'b0;
            if (cnt_inc_d == TMO_C) begin
              fail_q   <= 1'b1;
              state_q  <= DONE;
              clk_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign ccff_head    = head_q;
  assign ccff_clk_en  = clk_en_q;
  assign busy         = busy_q;
  assign config_done  = done_q;
  assign check_pass   = pass_q;
  assign check_fail   = fail_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed/randomized bench for ccff_loader: three instances (40x8, 37x8, 29647x32)
// checked against a flattened-bitstream reference and a behavioural chain model.
module tb_ccff_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        pReset;
  logic        st_ld[3];
  logic        st_ck[3];
  logic        sval[3];
  logic [31:0] sdat[3];
  logic        rdy[3];
  logic        en[3];
  logic        hd[3];
  logic        bsy[3];
  logic        dn[3];
  logic        ps[3];
  logic        fl[3];
  logic [15:0] cnt[3];
  logic        tail;

  ccff_loader_if #(.WORD_W(8))  if_a ();
  ccff_loader_if #(.WORD_W(8))  if_b ();
  ccff_loader_if #(.WORD_W(32)) if_c ();

  assign if_a.s_data  = sdat[0][7:0];
  assign if_a.s_valid = sval[0];
  assign rdy[0]       = if_a.s_ready;
  assign if_b.s_data  = sdat[1][7:0];
  assign if_b.s_valid = sval[1];
  assign rdy[1]       = if_b.s_ready;
  assign if_c.s_data  = sdat[2];
  assign if_c.s_valid = sval[2];
  assign rdy[2]       = if_c.s_ready;

  ccff_loader #(.CHAIN_LEN(40), .WORD_W(8), .CNT_W(16), .CHECK_MARGIN(8)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start_load(st_ld[0]), .start_check(st_ck[0]),
    .s_if(if_a), .ccff_head(hd[0]), .ccff_clk_en(en[0]), .ccff_tail(tail),
    .busy(bsy[0]), .config_done(dn[0]), .check_pass(ps[0]), .check_fail(fl[0]),
    .bit_count(cnt[0]));

  ccff_loader #(.CHAIN_LEN(37), .WORD_W(8), .CNT_W(16), .CHECK_MARGIN(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start_load(st_ld[1]), .start_check(st_ck[1]),
    .s_if(if_b), .ccff_head(hd[1]), .ccff_clk_en(en[1]), .ccff_tail(1'b0),
    .busy(bsy[1]), .config_done(dn[1]), .check_pass(ps[1]), .check_fail(fl[1]),
    .bit_count(cnt[1]));

  ccff_loader #(.CHAIN_LEN(29647), .WORD_W(32), .CNT_W(16), .CHECK_MARGIN(8)) dut_c (
    .prog_clk(prog_clk), .pReset(pReset), .start_load(st_ld[2]), .start_check(st_ck[2]),
    .s_if(if_c), .ccff_head(hd[2]), .ccff_clk_en(en[2]), .ccff_tail(1'b0),
    .busy(bsy[2]), .config_done(dn[2]), .check_pass(ps[2]), .check_fail(fl[2]),
    .bit_count(cnt[2]));

  // Behavioural fabric chain for instance A; mlen==0 models a tail tied low.
  logic [63:0] chain;
  int          mlen;
  logic        chain_clr;
  always @(posedge prog_clk) begin
    if (chain_clr) chain <= '0;
    else if (en[0]) chain <= {chain[62:0], hd[0]};
  end
  assign tail = (mlen > 0) ? chain[6'(mlen - 1)] : 1'b0;

  // Shift monitor: records every enabled head bit of the active instance.
  int   act;
  logic mon_clr;
  bit   obsq[$];
  logic en_prev, dn_prev, gap_ok;
  always @(negedge prog_clk) begin
    if (mon_clr) begin
      obsq.delete();
      en_prev <= 1'b0;
      dn_prev <= 1'b0;
      gap_ok  <= 1'b0;
    end else begin
      if (en[act]) obsq.push_back(hd[act]);
      if (dn[act] && !dn_prev) gap_ok <= en_prev && !en[act];
      en_prev <= en[act];
      dn_prev <= dn[act];
    end
  end

  logic [31:0] wq[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endfunction

  // Reference: the bitstream is the word list flattened LSB-first.
  function automatic bit exp_bit(input int i, input int ww);
    logic [31:0] w;
    w = wq[i / ww];
    return w[i % ww];
  endfunction

  task automatic mon_reset();
    @(posedge prog_clk); mon_clr = 1'b1;
    @(posedge prog_clk); mon_clr = 1'b0;
  endtask

  task automatic make_words(input int n, input logic [31:0] mask);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom & mask);
  endtask

  task automatic run_load(input int d, input int clen, input int ww, input string tag,
                          input int stall_at, input int chk_at, input bit both, input int abort_at);
    int hs, k, guard, stall_left, bad;
    bit chk_sent, stall_ok, aborted;
    act = d;
    mon_reset();
    @(negedge prog_clk); st_ld[d] = 1'b1; st_ck[d] = both;
    @(negedge prog_clk); st_ld[d] = 1'b0; st_ck[d] = 1'b0;
    chk({tag, ".busy_start"}, bsy[d], 1);
    chk({tag, ".ready_start"}, rdy[d], 1);
    hs = 0; k = 0; guard = 0; stall_left = 10; chk_sent = 0; stall_ok = 1; aborted = 0;
    while (!dn[d] && guard < 40000) begin
      if (abort_at >= 0 && int'(cnt[d]) == abort_at) begin
        aborted = 1;
        break;
      end
      if (hs == stall_at && rdy[d] && stall_left > 0) begin
        sval[d] = 1'b0;
        stall_left--;
        if (en[d]) stall_ok = 0;
      end else begin
        sval[d] = 1'b1;
        sdat[d] = (k < wq.size()) ? wq[k] : 32'h0;
        if (rdy[d]) begin
          hs++;
          k++;
        end
      end
      st_ck[d] = (chk_at >= 0 && hs == chk_at && !chk_sent);
      if (st_ck[d]) chk_sent = 1;
      @(negedge prog_clk);
      guard++;
    end
    sval[d]  = 1'b0;
    st_ck[d] = 1'b0;
    if (aborted) begin
      #2 pReset = 1'b0;
      #1;
      chk({tag, ".rst_outputs"}, {en[d], bsy[d], dn[d], ps[d], fl[d], rdy[d], hd[d]}, 0);
      chk({tag, ".rst_count"}, cnt[d], 0);
      #1 pReset = 1'b1;
      return;
    end
    chk({tag, ".done"}, dn[d], 1);
    @(negedge prog_clk);
    bad = 0;
    for (int i = 0; i < clen; i++)
      if (i >= obsq.size() || obsq[i] !== exp_bit(i, ww)) bad++;
    chk({tag, ".shifts"}, obsq.size(), clen);
    chk({tag, ".bad_bits"}, bad, 0);
    chk({tag, ".handshakes"}, hs, (clen + ww - 1) / ww);
    chk({tag, ".done_after_last_shift"}, gap_ok, 1);
    chk({tag, ".status"}, {bsy[d], ps[d], fl[d], cnt[d]}, {3'b000, 16'(clen)});
    if (stall_at >= 0) chk({tag, ".stall"}, {stall_ok, 8'(stall_left)}, {1'b1, 8'd0});
  endtask

  task automatic run_check(input int ml, input string tag, input bit exp_pass, input int exp_cnt);
    int guard, ones;
    act = 0;
    @(negedge prog_clk); chain_clr = 1'b1; mlen = ml;
    @(negedge prog_clk); chain_clr = 1'b0;
    mon_reset();
    @(negedge prog_clk); st_ck[0] = 1'b1;
    @(negedge prog_clk); st_ck[0] = 1'b0;
    chk({tag, ".busy_start"}, bsy[0], 1);
    guard = 0;
    while (bsy[0] && guard < 200) begin
      @(negedge prog_clk);
      guard++;
    end
    @(negedge prog_clk);
    chk({tag, ".result"}, {bsy[0], ps[0], fl[0]}, {1'b0, exp_pass, !exp_pass});
    chk({tag, ".count"}, cnt[0], exp_cnt);
    ones = 0;
    foreach (obsq[i]) ones += int'(obsq[i]);
    chk({tag, ".first_head"}, (obsq.size() > 0) ? obsq[0] : 1'b0, 1);
    chk({tag, ".single_pulse"}, ones, 1);
    if (ml == 0) chk({tag, ".timeout_shifts"}, obsq.size(), exp_cnt);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st_ld[i] = 1'b0; st_ck[i] = 1'b0; sval[i] = 1'b0; sdat[i] = '0;
    end
    pReset = 1'b0; mlen = 0; chain_clr = 1'b0; mon_clr = 1'b0; act = 0;
    repeat (3) @(negedge prog_clk);
    chk("reset.outputs", {en[0], bsy[0], dn[0], ps[0], fl[0], rdy[0], hd[0]}, 0);
    chk("reset.count", cnt[0], 0);
    @(negedge prog_clk); pReset = 1'b1;

    wq.delete();
    wq.push_back(32'h01); wq.push_back(32'h80); wq.push_back(32'hFF);
    wq.push_back(32'h00); wq.push_back(32'hA5);
    run_load(0, 40, 8, "t1", -1, -1, 1'b0, -1);

    make_words(5, 32'hFF);
    wq[4] = wq[4] | 32'hE0;
    run_load(1, 37, 8, "t2", 2, -1, 1'b0, -1);

    run_check(40, "t3", 1'b1, 40);
    run_check(39, "t4_short", 1'b0, 39);
    run_check(0, "t4_tied0", 1'b0, 48);

    make_words(5, 32'hFF);
    run_load(0, 40, 8, "t5_abort", -1, -1, 1'b0, 20);
    @(negedge prog_clk);
    chk("t5.status_after_reset", {bsy[0], dn[0], ps[0], fl[0], en[0]}, 0);
    make_words(5, 32'hFF);
    run_load(0, 40, 8, "t5_reload", -1, -1, 1'b0, -1);

    make_words(5, 32'hFF);
    run_load(0, 40, 8, "t6", -1, 3, 1'b1, -1);

    make_words(927, 32'hFFFF_FFFF);
    run_load(2, 29647, 32, "full", -1, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
